// File: rtl/tx_symbol_scheduler.sv
// Transmit symbol scheduler: data/idle/SKP arbitration ahead of the
// 8b/10b encoder pair, plus running-disparity feedback chain.
module tx_symbol_scheduler #(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned SKP_COUNT    = 3,
  parameter logic        RD_INIT      = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [7:0] s_data_i,
  input  logic       s_is_k_i,
  input  logic       s_valid_i,
  input  logic       s_lock_i,
  output logic       s_ready_o,
  output logic [7:0] enc_data_o,
  output logic       enc_is_k_o,
  output logic       enc_valid_o,
  output logic       enc_rd_n_o,
  input  logic       rd_fb_i,
  output logic       skp_pending_o,
  output logic       skp_active_o
);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_DATA,
    ST_COM,
    ST_SKP
  } state_t;

  localparam logic [10:0] CNT_LAST = 11'(SKP_INTERVAL - 1);
  localparam logic [2:0]  SUB_LAST = 3'(SKP_COUNT - 1);
  localparam logic [7:0]  K28_5    = 8'hBC;
  localparam logic [7:0]  K28_0    = 8'h1C;
  localparam logic [7:0]  IDLE     = 8'h00;

  state_t      state_q;
  state_t      state_d;
  logic [10:0] cnt_q;
  logic [10:0] cnt_d;
  logic [10:0] cnt_inc;
  logic        pend_q;
  logic        pend_d;
  logic [2:0]  sub_q;
  logic [2:0]  sub_d;
  logic [7:0]  data_d;
  logic        is_k_d;
  logic        valid_d;
  logic        active_d;
  logic        skp_go;
  logic        rd_q;
  logic        prev_valid_q;

  assign cnt_inc = cnt_q + 11'd1;
  assign skp_go  = pend_q & ~s_lock_i;

  assign s_ready_o = en_i
                   & (state_q == ST_DATA)
                   & ~skp_go;

  assign skp_pending_o = pend_q;

  // Encoder RD is only trusted the cycle after it produced a symbol.
  assign enc_rd_n_o = prev_valid_q ? rd_fb_i : rd_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    sub_d    = sub_q;
    data_d   = IDLE;
    is_k_d   = 1'b0;
    valid_d  = 1'b0;
    active_d = 1'b0;
    unique case (state_q)
      ST_OFF: begin
        if (en_i) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (!en_i) begin
          state_d = ST_OFF;
        end else begin
          valid_d = 1'b1;
          if (s_valid_i && s_ready_o) begin
            data_d = s_data_i;
            is_k_d = s_is_k_i;
          end
          if (skp_go) begin
            state_d = ST_COM;
            pend_d  = 1'b0;
            cnt_d   = '0;
          end else if (!pend_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_LAST) pend_d = 1'b1;
          end
        end
      end
      ST_COM: begin
        valid_d  = 1'b1;
        data_d   = K28_5;
        is_k_d   = 1'b1;
        active_d = 1'b1;
        sub_d    = '0;
        state_d  = ST_SKP;
      end
      ST_SKP: begin
        valid_d  = 1'b1;
        data_d   = K28_0;
        is_k_d   = 1'b1;
        active_d = 1'b1;
        sub_d    = sub_q + 3'd1;
        // Ordered set always runs to completion, en_i only picks the exit.
        if (sub_q == SUB_LAST) begin
          sub_d   = '0;
          state_d = en_i ? ST_DATA : ST_OFF;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_OFF;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      sub_q        <= '0;
      enc_data_o   <= IDLE;
      enc_is_k_o   <= 1'b0;
      enc_valid_o  <= 1'b0;
      skp_active_o <= 1'b0;
      prev_valid_q <= 1'b0;
      rd_q         <= RD_INIT;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      sub_q        <= sub_d;
      enc_data_o   <= data_d;
      enc_is_k_o   <= is_k_d;
      enc_valid_o  <= valid_d;
      skp_active_o <= active_d;
      prev_valid_q <= enc_valid_o;
      if (prev_valid_q) rd_q <= rd_fb_i;
    end
  end

endmodule

// File: tb/tb_tx_symbol_scheduler.sv
// Directed bench for tx_symbol_scheduler with a short SKP interval
// and a toggling-RD encoder stand-in.
module tb_tx_symbol_scheduler;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] s_data;
  logic       s_is_k;
  logic       s_valid;
  logic       s_lock;
  logic       s_ready;
  logic [7:0] enc_data;
  logic       enc_is_k;
  logic       enc_valid;
  logic       enc_rd_n;
  logic       rd_fb;
  logic       skp_pending;
  logic       skp_active;

  int tests;
  int fails;

  tx_symbol_scheduler #(
    .SKP_INTERVAL(8),
    .SKP_COUNT(3),
    .RD_INIT(1'b1)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .en_i(en),
    .s_data_i(s_data),
    .s_is_k_i(s_is_k),
    .s_valid_i(s_valid),
    .s_lock_i(s_lock),
    .s_ready_o(s_ready),
    .enc_data_o(enc_data),
    .enc_is_k_o(enc_is_k),
    .enc_valid_o(enc_valid),
    .enc_rd_n_o(enc_rd_n),
    .rd_fb_i(rd_fb),
    .skp_pending_o(skp_pending),
    .skp_active_o(skp_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Unbalanced-symbol encoder: post-symbol RD flips; garbage when idle.
  task automatic tick();
    logic nfb;
    nfb = enc_valid ? ~enc_rd_n : 1'b1;
    @(posedge clk);
    #1 rd_fb = nfb;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    tests   = 0;
    fails   = 0;
    rst     = 1'b1;
    en      = 1'b0;
    s_data  = 8'h00;
    s_is_k  = 1'b0;
    s_valid = 1'b0;
    s_lock  = 1'b0;
    rd_fb   = 1'b1;
    tick();
    tick();

    chk("rst_valid", enc_valid, 0);
    chk("rst_data", enc_data, 8'h00);
    chk("rst_is_k", enc_is_k, 0);
    chk("rst_pending", skp_pending, 0);
    chk("rst_active", skp_active, 0);
    chk("rst_rd_n", enc_rd_n, 1);
    chk("rst_ready", s_ready, 0);

    // Continuous locked data
    rst    = 1'b0;
    en     = 1'b1;
    s_lock = 1'b1;
    tick();
    chk("off_to_data_valid", enc_valid, 0);
    for (int i = 1; i <= 5; i++) begin
      s_data  = 8'(i);
      s_valid = 1'b1;
      #1 chk("data_ready", s_ready, 1);
      tick();
      chk("data_byte", enc_data, i);
      chk("data_valid", enc_valid, 1);
      chk("data_is_k", enc_is_k, 0);
    end
    s_valid = 1'b0;
    tick();
    tick();
    chk("expiry_pending", skp_pending, 1);
    chk("expiry_idle", enc_data, 8'h00);

    // Deferral while locked
    for (int i = 0; i < 5; i++) begin
      s_data  = 8'(8'h10 + i);
      s_valid = 1'b1;
      #1 chk("defer_ready", s_ready, 1);
      tick();
      chk("defer_byte", enc_data, 8'h10 + i);
      chk("defer_pending", skp_pending, 1);
      chk("defer_active", skp_active, 0);
    end
    s_lock = 1'b0;
    s_data = 8'h55;
    #1 chk("unlock_ready", s_ready, 0);
    tick();
    chk("unlock_idle", enc_data, 8'h00);
    chk("unlock_pending", skp_pending, 0);
    chk("unlock_active", skp_active, 0);
    #1 chk("com_state_ready", s_ready, 0);
    tick();
    chk("defer_com", enc_data, 8'hBC);
    chk("defer_com_k", enc_is_k, 1);
    chk("defer_com_active", skp_active, 1);
    s_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("defer_skp", enc_data, 8'h1C);
      chk("defer_skp_active", skp_active, 1);
    end

    // Idle-driven insertion: eight idles, then COM + 3 SKP
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("ins_idle", enc_data, 8'h00);
      chk("ins_idle_active", skp_active, 0);
      chk("ins_pending", skp_pending, (k == 6) ? 1 : 0);
    end
    tick();
    chk("ins_com", enc_data, 8'hBC);
    chk("ins_com_k", enc_is_k, 1);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("ins_skp", enc_data, 8'h1C);
      chk("ins_skp_valid", enc_valid, 1);
    end
    tick();
    chk("ins_resume", enc_data, 8'h00);
    chk("ins_resume_active", skp_active, 0);
    chk("ins_resume_valid", enc_valid, 1);

    // en_i dropped while COM is on the line
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("drop_idle", enc_data, 8'h00);
    end
    tick();
    chk("drop_com", enc_data, 8'hBC);
    en = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("drop_skp", enc_data, 8'h1C);
      chk("drop_skp_valid", enc_valid, 1);
    end
    tick();
    chk("drop_off_valid", enc_valid, 0);
    chk("drop_off_ready", s_ready, 0);

    // RD chain from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en  = 1'b1;
    tick();
    chk("rd_start", enc_rd_n, 1);
    tick();
    chk("rd_sym1", enc_rd_n, 1);
    tick();
    chk("rd_sym2", enc_rd_n, 0);
    tick();
    chk("rd_sym3", enc_rd_n, 1);
    en = 1'b0;
    tick();
    chk("rd_gap1_valid", enc_valid, 0);
    chk("rd_gap1", enc_rd_n, 0);
    tick();
    chk("rd_gap2", enc_rd_n, 0);
    tick();
    chk("rd_gap3", enc_rd_n, 0);
    en = 1'b1;
    tick();
    chk("rd_reen", enc_rd_n, 0);
    tick();
    chk("rd_held_valid", enc_valid, 1);
    chk("rd_held", enc_rd_n, 0);
    tick();
    chk("rd_next", enc_rd_n, 1);

    // Reset on the second SKP
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (enc_data == 8'hBC && skp_active) found = 1'b1;
    end
    chk("rstskp_com_seen", found, 1);
    tick();
    tick();
    chk("rstskp_second", enc_data, 8'h1C);
    rst = 1'b1;
    tick();
    chk("rstskp_valid", enc_valid, 0);
    chk("rstskp_rd_n", enc_rd_n, 1);
    chk("rstskp_pending", skp_pending, 0);
    chk("rstskp_active", skp_active, 0);
    rst = 1'b0;
    tick();
    tick();
    chk("rstskp_resume", enc_data, 8'h00);
    chk("rstskp_resume_active", skp_active, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
